hls_mem_responder: RTL and testbench

Memory responder that services the load/store requests issued by HLS-generated datapaths. Sits on the memory side of each `load`/`store` builtin: accepts one request per cycle over a valid/ready channel, performs the array write or read, and returns load data in order over a buffered response channel. Intended as the default backing RAM in generated top-levels and testbenches.

---
 rtl/hls_mem_responder.sv | 126 ++++++++++++
 tb/tb_hls_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hls_mem_responder.sv
// rtl/hls_mem_responder.sv - in-order load/store memory responder for HLS datapaths
//
// Backing RAM for HLS load/store builtins. Accepts one request per cycle on a
// valid/ready channel. A store writes the array at the accept edge. A load
// reads the array at the accept edge and queues the word in a 2-entry
// response FIFO, which is drained in request order.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset (memory contents retained)
//   req_valid     request present
//   req_ready     request can be accepted this cycle
//   req_is_store  1 = store, 0 = load
//   req_addr      word index (not a byte address)
//   req_wdata     store data
//   resp_valid    load data available
//   resp_ready    consumer takes the response this cycle
//   resp_data     head load word (0 while empty)
//   err_oob       sticky out-of-range flag
//
// Optional feature macro: HLS_MEM_OOB_CHECK_EN
//   defined     -> addresses >= DEPTH drop stores, return 0 for loads, set err_oob
//   not defined -> addresses wrap modulo DEPTH, err_oob tied to 0

module hls_mem_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  err_oob
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] fifo [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic             req_fire;
  logic             resp_fire;
  logic             store_fire;
  logic             load_fire;
  logic             addr_oob;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] load_word;

  assign resp_valid = (count != 2'd0);
  assign resp_fire  = resp_valid && resp_ready;
  // A full FIFO can still accept when the head pops in the same cycle.
  assign req_ready  = !rst && ((count < 2'd2) || resp_fire);
  assign req_fire   = req_valid && req_ready;
  assign store_fire = req_fire && req_is_store;
  assign load_fire  = req_fire && !req_is_store;

  assign idx = req_addr[IDX_W-1:0];

`ifdef HLS_MEM_OOB_CHECK_EN
  assign addr_oob = (req_addr >= ADDR_WIDTH'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob <= 1'b0;
    end else if (req_fire && addr_oob) begin
      err_oob <= 1'b1;
    end
  end
`else
  // Upper address bits are deliberately discarded so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:IDX_W];
  assign addr_oob         = 1'b0;
  assign err_oob          = 1'b0;
`endif

  assign load_word = addr_oob ? '0 : mem[idx];

  // Memory array: never reset. The write lands at the accept edge, so a load
  // accepted in any later cycle reads the new value straight from the array.
  always_ff @(posedge clk) begin
    if (store_fire && !addr_oob) begin
      mem[idx] <= req_wdata;
    end
  end

  // FIFO storage needs no reset: resp_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      fifo[wr_ptr] <= load_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (load_fire) begin
        wr_ptr <= ~wr_ptr;
      end
      if (resp_fire) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({load_fire, resp_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign resp_data = resp_valid ? fifo[rd_ptr] : '0;

endmodule

// File: tb/tb_hls_mem_responder.sv
// tb/tb_hls_mem_responder.sv - scoreboard bench for hls_mem_responder

module tb_hls_mem_responder;

  localparam int WIDTH      = 32;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 32;

`ifdef HLS_MEM_OOB_CHECK_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_data;
  logic                  err_oob;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  hls_mem_responder #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .err_oob(err_oob)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          check("resp_data", resp_data, exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        if (req_is_store) begin
          if (!(OOB_EN && req_addr >= DEPTH)) model[req_addr % DEPTH] = req_wdata;
        end else begin
          if (OOB_EN && req_addr >= DEPTH) exp_q.push_back('0);
          else exp_q.push_back(model[req_addr % DEPTH]);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic st, input int addr, input logic [WIDTH-1:0] wd, input logic rr);
    req_valid    = v;
    req_is_store = st;
    req_addr     = ADDR_WIDTH'(addr);
    req_wdata    = wd;
    resp_ready   = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (resp_valid && budget > 0) begin
      step();
      budget--;
    end
    check("drain_timeout", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 0, '0, 1'b1);
    step();
    step();
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_data", resp_data, 32'd0);
    check("reset_err_oob", 32'(err_oob), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    step();

    // Store then load next cycle: one-cycle load latency.
    drive(1'b1, 1'b1, 3, 32'hDEADBEEF, 1'b1);
    step();
    drive(1'b1, 1'b0, 3, '0, 1'b1);
    step();
    check("latency_valid", 32'(resp_valid), 32'd1);
    check("latency_data", resp_data, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    step();
    check("latency_drained", 32'(resp_valid), 32'd0);

    // Stores 1..8 then back-to-back loads with resp_ready high.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, i, WIDTH'(i + 1), 1'b1);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, i, '0, 1'b1);
      check($sformatf("b2b_req_ready_%0d", i), 32'(req_ready), 32'd1);
      step();
      check($sformatf("b2b_resp_valid_%0d", i), 32'(resp_valid), 32'd1);
      check($sformatf("b2b_resp_data_%0d", i), resp_data, WIDTH'(i + 1));
    end
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    drain();

    // Backpressure: two loads accepted, third stalls until a pop.
    drive(1'b1, 1'b0, 0, '0, 1'b0);
    check("bp_ready_0", 32'(req_ready), 32'd1);
    step();
    drive(1'b1, 1'b0, 1, '0, 1'b0);
    check("bp_ready_1", 32'(req_ready), 32'd1);
    step();
    drive(1'b1, 1'b0, 2, '0, 1'b0);
    check("bp_ready_full", 32'(req_ready), 32'd0);
    step();
    check("bp_ready_still_full", 32'(req_ready), 32'd0);
    check("bp_head", resp_data, 32'd1);
    resp_ready = 1'b1;
    #1;
    check("bp_ready_on_pop", 32'(req_ready), 32'd1);
    step();
    check("bp_head_after_pop", resp_data, 32'd2);
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    drain();

    // Reset with two loads pending; memory survives, reset-cycle request ignored.
    drive(1'b1, 1'b0, 5, '0, 1'b0);
    step();
    drive(1'b1, 1'b0, 6, '0, 1'b0);
    step();
    check("rst_pending_valid", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 0, 32'h00000BAD, 1'b0);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    drive(1'b1, 1'b0, 0, '0, 1'b1);
    step();
    check("post_rst_load", resp_data, 32'd1);
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    drain();

    // Address 16 handling with DEPTH=16.
    drive(1'b1, 1'b1, 16, 32'h55, 1'b1);
    step();
`ifdef HLS_MEM_OOB_CHECK_EN
    check("oob_set", 32'(err_oob), 32'd1);
    drive(1'b1, 1'b0, 16, '0, 1'b1);
    step();
    check("oob_load_zero", resp_data, 32'd0);
    drive(1'b1, 1'b0, 0, '0, 1'b1);
    step();
    check("oob_addr0_kept", resp_data, 32'd1);
    check("oob_sticky", 32'(err_oob), 32'd1);
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    drain();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("oob_cleared", 32'(err_oob), 32'd0);
`else
    check("wrap_no_err", 32'(err_oob), 32'd0);
    drive(1'b1, 1'b0, 0, '0, 1'b1);
    step();
    check("wrap_load", resp_data, 32'h55);
    check("wrap_no_err_after", 32'(err_oob), 32'd0);
    drive(1'b0, 1'b0, 0, '0, 1'b1);
    drain();
`endif

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
